// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the bit-serial sequence detector path.
package seqdet_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // A zero length would match nothing sensible, so it behaves as a single bit.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_max);
    if (len == 0) return 1;
    if (len > pat_max) return pat_max;
    return len;
  endfunction

endpackage

// File: rtl/seqdet_matcher.sv
// Overlapping pattern matcher over a serial bit stream; match is combinational
// on the post-shift history so the caller can register it on the same edge.
module seqdet_matcher
  import seqdet_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         bit_in,
  input  logic                         valid_in,
  input  logic [PAT_MAX-1:0]           pattern_in,
  input  logic [$clog2(PAT_MAX+1)-1:0] len_in,
  output logic                         match_o
);

  localparam int LEN_W = $clog2(PAT_MAX+1);

  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [PAT_MAX-1:0] len_mask;

  genvar gi;
  generate
    for (gi = 0; gi < PAT_MAX; gi++) begin : g_mask
      assign len_mask[gi] = (len_in > LEN_W'(gi));
    end
  endgenerate

  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    if (clr) begin
      hist_d = '0;
      seen_d = '0;
    end else if (valid_in) begin
      hist_d = (hist_q << 1) | PAT_MAX'(bit_in);
      if (seen_q != LEN_W'(PAT_MAX)) seen_d = seen_q + 1'b1;
    end
  end

  // The seen check stops a stale all-zero history from matching a zero pattern.
  assign match_o = valid_in && !clr
                && (((hist_d ^ pattern_in) & len_mask) == '0)
                && (seen_d >= len_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      seen_q <= '0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/seqdet_stream_ctrl.sv
// Word-to-bit serializer with session FSM, hit counter and sticky threshold irq
// around the serial pattern matcher.
module seqdet_stream_ctrl
  import seqdet_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]             cfg_thresh,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         busy,
  output logic                         ser_bit,
  output logic                         ser_valid,
  output logic                         hit,
  output logic [CNT_W-1:0]             hit_count,
  output logic                         irq,
  input  logic                         clr_irq
);

  localparam int LEN_W  = $clog2(PAT_MAX+1);
  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W-1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               stop_q, stop_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               ser_bit_q, ser_bit_d;
  logic               ser_valid_q, ser_valid_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_plus;
  logic               irq_q, irq_d;

  logic hs, stop_req, session_clr, match, cnt_inc, irq_set;

  assign hs          = in_valid && in_ready_q;
  assign stop_req    = stop_q || stop;
  assign session_clr = (state_q == IDLE) && start;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bcnt_d   = bcnt_q;
    stop_d   = stop_q;
    pat_d    = pat_q;
    len_d    = len_q;
    thresh_d = thresh_q;
    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          pat_d    = cfg_pattern;
          len_d    = LEN_W'(clamp_len(32'(cfg_len), PAT_MAX));
          thresh_d = cfg_thresh;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (hs) begin
          sreg_d  = in_data;
          bcnt_d  = '0;
          stop_d  = stop_req;
          state_d = SHIFT;
        end else if (stop_req) begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        stop_d = stop_req;
        if (bcnt_q == LAST_BIT) begin
          // An accepted word outranks a pending stop; stop stays latched for it.
          if (hs) begin
            sreg_d = in_data;
            bcnt_d = '0;
          end else if (stop_req) begin
            stop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          sreg_d = sreg_q << 1;
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_d  = (state_d == WAIT) || ((state_d == SHIFT) && (bcnt_d == LAST_BIT));
  assign busy_d      = (state_d != IDLE);
  assign ser_valid_d = (state_d == SHIFT);
  assign ser_bit_d   = (state_d == SHIFT) && sreg_d[DATA_W-1];

  seqdet_matcher #(
    .PAT_MAX (PAT_MAX)
  ) u_matcher (
    .clk        (clk),
    .rst        (rst),
    .clr        (session_clr),
    .bit_in     (ser_bit_q),
    .valid_in   (ser_valid_q),
    .pattern_in (pat_q),
    .len_in     (len_q),
    .match_o    (match)
  );

  assign cnt_plus = cnt_q + 1'b1;
  assign cnt_inc  = match && (cnt_q != '1);
  assign irq_set  = cnt_inc && (cnt_plus == thresh_q) && (thresh_q != '0);

  always_comb begin
    hit_d = match;
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (session_clr) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end else begin
      if (cnt_inc) cnt_d = cnt_plus;
      if (irq_set)      irq_d = 1'b1;
      else if (clr_irq) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bcnt_q      <= '0;
      stop_q      <= 1'b0;
      pat_q       <= '0;
      len_q       <= LEN_W'(1);
      thresh_q    <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bcnt_q      <= bcnt_d;
      stop_q      <= stop_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      thresh_q    <= thresh_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign hit       = hit_q;
  assign hit_count = cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Directed and random sessions against a bit-list reference model; a second
// instance with a 2-bit counter exercises counter saturation.
module tb_seqdet_stream_ctrl;

  localparam int DW = 8;
  localparam int PM = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PM-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic [CW-1:0] cfg_thresh;
  logic [1:0]    cfg_thresh2;
  logic          start, stop, in_valid, clr_irq;
  logic [DW-1:0] in_data;
  logic          in_ready, busy, ser_bit, ser_valid, hit, irq;
  logic [CW-1:0] hit_count;
  logic          in_ready2, busy2, ser_bit2, ser_valid2, hit2, irq2;
  logic [1:0]    hit_count2;

  seqdet_stream_ctrl #(.DATA_W(DW), .PAT_MAX(PM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy), .ser_bit(ser_bit),
    .ser_valid(ser_valid), .hit(hit), .hit_count(hit_count), .irq(irq),
    .clr_irq(clr_irq)
  );

  seqdet_stream_ctrl #(.DATA_W(DW), .PAT_MAX(PM), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh2), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready2), .busy(busy2), .ser_bit(ser_bit2),
    .ser_valid(ser_valid2), .hit(hit2), .hit_count(hit_count2), .irq(irq2),
    .clr_irq(clr_irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the session's bit stream plus the latched configuration.
  bit            hist_m[$];
  bit            exp_bits[$];
  logic [DW-1:0] words[$];
  logic [PM-1:0] m_pat;
  int            m_len, m_thresh, m_cnt, span;
  bit            m_irq, m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_match();
    if (hist_m.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (hist_m[hist_m.size()-1-k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic begin_session(input logic [PM-1:0] p, input int l, input int th);
    cfg_pattern = p;
    cfg_len     = 4'(l);
    cfg_thresh  = CW'(th);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble cfg: the session must keep using the latched copy.
    cfg_pattern = PM'($urandom);
    cfg_len     = 4'($urandom);
    cfg_thresh  = CW'($urandom);
    m_pat = p;
    m_len = (l == 0) ? 1 : ((l > PM) ? PM : l);
    m_thresh = th;
    m_cnt = 0;
    m_irq = 1'b0;
    m_pend = 1'b0;
    hist_m.delete();
    exp_bits.delete();
    check("busy_after_start", busy, 1);
    check("count_after_start", hit_count, 0);
    check("irq_after_start", irq, 0);
    $display("session: pat=%0h len=%0d thresh=%0d", p, l, th);
  endtask

  // Streams words[] through the DUT; stop_pos<0 means stop with the final
  // handshake, otherwise stop is pulsed during that (0-based) session bit.
  task automatic stream(input bit no_bubble, input int stop_pos, input logic [63:0] clr_mask);
    int wi, gbit, first, last, cyc, limit;
    bit done, b, set;
    logic [DW-1:0] w;
    wi = 0; gbit = 0; first = -1; last = -1; cyc = 0; done = 1'b0;
    limit = 40 * (words.size() + 2);
    while (!done) begin
      check("hit", hit, m_pend);
      check("hit_count", hit_count, m_cnt);
      check("irq", irq, m_irq);
      if (!busy) begin
        check("in_ready_idle", in_ready, 0);
        done = 1'b1;
      end else if (cyc > limit) begin
        check("timeout_busy", busy, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        done = 1'b1;
      end else begin
        stop = 1'b0; clr_irq = 1'b0; in_valid = 1'b0; m_pend = 1'b0;
        if (ser_valid) begin
          if (exp_bits.size() == 0) begin
            check("ser_valid_unexpected", ser_valid, 0);
          end else begin
            check("in_ready_shift", in_ready, exp_bits.size() == 1);
            b = exp_bits.pop_front();
            check("ser_bit", ser_bit, b);
            if (first < 0) first = cyc;
            last = cyc;
            clr_irq = (gbit < 64) ? clr_mask[gbit] : 1'b0;
            if (gbit == stop_pos) stop = 1'b1;
            hist_m.push_back(b);
            m_pend = model_match();
            set = 1'b0;
            if (m_pend && m_cnt != (1 << CW) - 1) begin
              m_cnt++;
              set = (m_cnt == m_thresh) && (m_thresh != 0);
            end
            if (set) m_irq = 1'b1;
            else if (clr_irq) m_irq = 1'b0;
            gbit++;
          end
        end else begin
          check("in_ready_wait", in_ready, 1);
        end
        if (wi < words.size() && (no_bubble || $urandom_range(3) != 0)) begin
          w = words[wi];
          in_valid = 1'b1;
          in_data = w;
          if (in_ready) begin
            for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(w[i]);
            $display("word %0d accepted: %0h", wi, w);
            wi++;
            if (wi == words.size() && stop_pos < 0) stop = 1'b1;
          end
        end
        tick();
        cyc++;
      end
    end
    stop = 1'b0; clr_irq = 1'b0; in_valid = 1'b0;
    span = last - first + 1;
    check("bits_left", exp_bits.size(), 0);
    check("small_count", hit_count2, (m_cnt > 3) ? 3 : m_cnt);
    check("small_irq", irq2, 0);
    $display("session end: hits=%0d irq=%0b cycles=%0d", hit_count, irq, cyc);
  endtask

  initial begin
    cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0; cfg_thresh2 = 2'b00;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; clr_irq = 1'b0; in_data = '0;

    // Asynchronous reset values.
    #2 rst = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_bit", ser_bit, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_irq", irq, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Overlapping matches within one word.
    begin_session(8'b101, 3, 3);
    words = '{8'hAA};
    stream(1'b1, -1, 64'h0);
    check("t1_count", hit_count, 3);
    check("t1_irq", irq, 1);

    // Match across back-to-back words with no bubble.
    begin_session(8'b101, 3, 0);
    words = '{8'h01, 8'h40};
    stream(1'b1, -1, 64'h0);
    check("t2_count", hit_count, 1);
    check("t2_span", span, 16);

    // Stop mid-word: the word completes, then the session ends.
    begin_session(8'b101, 3, 0);
    words = '{8'hAA};
    stream(1'b1, 2, 64'h0);
    check("t3_count", hit_count, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_idle_busy", busy, 0);
      check("t3_idle_ready", in_ready, 0);
    end
    begin_session(8'b1, 1, 0);
    words = '{8'h0F};
    stream(1'b0, -1, 64'h0);

    // Reset in the middle of a word.
    begin_session(8'b111, 3, 0);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_ser_valid_pre", ser_valid, 1);
    check("t4_count_pre", hit_count, 1);
    rst = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_ser_valid", ser_valid, 0);
    check("t4_ser_bit", ser_bit, 0);
    check("t4_in_ready", in_ready, 0);
    check("t4_hit", hit, 0);
    check("t4_count", hit_count, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_after_busy", busy, 0);
      check("t4_after_hit", hit, 0);
      check("t4_after_count", hit_count, 0);
    end

    // Set beats clear on the threshold edge; a lone clear then drops irq.
    begin_session(8'b1, 1, 2);
    words = '{8'hC0};
    stream(1'b1, -1, 64'h12);
    check("t5_count", hit_count, 2);
    check("t5_irq", irq, 0);

    // Length 0 behaves as 1; the 2-bit counter saturates.
    begin_session(8'h01, 0, 0);
    words = '{8'hFF};
    stream(1'b1, -1, 64'h0);
    check("t6_count", hit_count, 8);
    check("t6_small_sat", hit_count2, 3);

    // Random sessions.
    for (int s = 0; s < 12; s++) begin
      int n, sp;
      begin_session(PM'($urandom), int'($urandom_range(0, 10)), int'($urandom_range(0, 6)));
      n = int'($urandom_range(1, 4));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
      sp = ($urandom_range(1) == 0) ? -1 : (n - 1) * DW + int'($urandom_range(0, DW - 1));
      stream(1'($urandom), sp, {32'h0, $urandom & $urandom & $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
